spi_tx_seq: RTL
===============

// Module: spi_tx_seq
// PURPOSE
//   Master-mode transfer sequencer for the SPI TX shifter. Paces a frame of tnum_max data words
//   plus an optional CRC word, and generates sck and cs_n with setup/hold timing.
//   Owns a 1-entry TX holding buffer (txe source) and gives the shifter load/shift strobes.
//   Sits between the register block (wdata/start) and the TX shift/CRC datapath.
// PARAMETERS
//   DIV_W   8   width of clk_div; sck half-period = clk_div+1 spi_clk cycles
//   NUM_W   13  width of tnum_max / frame_cnt
// PORTS
//   spi_clk     in   1      block clock
//   spi_rst     in   1      synchronous, active-high reset
//   start       in   1      1-cycle pulse: begin transfer (ignored while busy)
//   abort       in   1      1-cycle pulse: terminate transfer immediately
//   clk_div     in   DIV_W  sck half-period minus 1
//   cpol        in   1      sck idle level
//   df          in   2      frame width: 00=8, 01=16, 1x=32 bits
//   tnum_max    in   NUM_W  data words per transfer (0 treated as 1)
//   crc_en      in   1      append one CRC word after last data word
//   cs_setup    in   4      spi_clk cycles cs_n low before first sck edge
//   cs_hold     in   4      spi_clk cycles after last bit before cs_n high
//   wdata       in   32     TX word from register block
//   wvalid      in   1      wdata valid
//   wready      out  1      buffer can accept wdata
//   txe         out  1      holding buffer empty
//   busy        out  1      transfer in progress (state != IDLE)
//   cs_n        out  1      chip select, active low
//   sck         out  1      serial clock
//   frame_load  out  1      1-cycle pulse: shifter loads frame_data
//   frame_data  out  32     word presented with frame_load
//   crc_sel     out  1      high while CRC word is shifting (shifter muxes CRC in)
//   bit_strobe  out  1      1-cycle pulse per bit, on trailing sck edge
//   frame_cnt   out  NUM_W  data words completed in current transfer
//   done        out  1      1-cycle pulse on normal completion
//   underrun    out  1      sticky: buffer empty when next word was due; cleared on start
// BEHAVIOUR
//   Reset: state IDLE, cs_n=1, sck=cpol, buffer empty (txe=1, wready=1), all pulses 0,
//     frame_cnt=0, underrun=0, crc_sel=0, frame_data=0.
//   Config (clk_div, cpol, df, tnum_max, crc_en, cs_setup, cs_hold) latched on accepted start.
//   Buffer: push on wvalid&wready; wready = ~full | frame_load (push and pop in the same cycle
//     allowed, buffer stays full). txe = ~full.
//   FSM: IDLE -start-> SETUP (cs_n=0, wait cs_setup cycles; 0 = one cycle) -> LOAD.
//     LOAD: if buffer full, frame_load=1, pop, -> SHIFT; else -> WAIT.
//     WAIT: cs_n held low, sck idle, underrun set on entry; -> LOAD when buffer full.
//     SHIFT: divider counts 0..clk_div; at terminal count sck toggles. Leading edge first,
//       trailing edge returns sck to cpol and pulses bit_strobe.
//       Bit period = 2*(clk_div+1) cycles. After 8/16/32 strobes the word ends:
//       data word: frame_cnt++; if frame_cnt<tnum_max -> LOAD; elif crc_en -> CRC; else -> HOLD.
//       CRC word ends -> HOLD.
//     CRC: frame_load=1 with crc_sel=1, frame_data=0, buffer not popped; same shift
//       sequence as SHIFT; crc_sel stays high until the word ends.
//     HOLD: wait cs_hold cycles (0 = one cycle) -> IDLE; on the exit cycle cs_n=1, done=1.
//   Next word after the final bit_strobe: frame_load 1 cycle later if buffer full, no extra cs_n gap.
//   abort (any non-IDLE state): next cycle IDLE, cs_n=1, sck=cpol, buffer flushed,
//     no done pulse, frame_cnt held. abort has priority over start in the same cycle.
//   start and abort in IDLE: abort wins, stay IDLE.
//   frame_cnt cleared on accepted start; saturates at tnum_max. sck never glitches on entry/exit.
//   spi_rst mid-transfer: all state returns to reset values the next cycle.
// TESTING
//   1) df=00, tnum_max=1, clk_div=1, cpol=0, cs_setup=2, cs_hold=2, wdata=A5 preloaded, start
//      -> 8 bit_strobes 4 cycles apart, frame_cnt=1, done once, cs_n high after hold.
//   2) df=01, tnum_max=3, words pushed back-to-back -> 3 frame_load pulses,
//      48 bit_strobes, no gap in sck, underrun=0.
//   3) tnum_max=2, second word pushed 20 cycles late -> WAIT entered, underrun=1,
//      cs_n stays low, transfer resumes, done once.
//   4) crc_en=1, tnum_max=2, df=1x -> 3 frames; crc_sel high only during the 3rd (32 strobes),
//      buffer not popped for CRC.
//   5) abort mid-SHIFT in frame 2 -> IDLE next cycle, cs_n=1, sck=cpol, txe=1, no done;
//      start with abort in the same cycle -> stays IDLE.
//   6) spi_rst asserted mid-transfer; cpol=1 run -> all outputs at reset values; sck idles high
//      with cpol=1; wvalid held while full -> wready=0 until frame_load.

Source files
------------

// File: rtl/spi_tx_seq.sv
// rtl/spi_tx_seq.sv - SPI master transfer sequencer: frame pacing, sck/cs_n timing, 1-entry TX buffer
module spi_tx_seq #(
    parameter int DIV_W = 8,
    parameter int NUM_W = 13
) (
    input  logic             spi_clk,
    input  logic             spi_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cpol,
    input  logic [1:0]       df,
    input  logic [NUM_W-1:0] tnum_max,
    input  logic             crc_en,
    input  logic [3:0]       cs_setup,
    input  logic [3:0]       cs_hold,
    input  logic [31:0]      wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic             txe,
    output logic             busy,
    output logic             cs_n,
    output logic             sck,
    output logic             frame_load,
    output logic [31:0]      frame_data,
    output logic             crc_sel,
    output logic             bit_strobe,
    output logic [NUM_W-1:0] frame_cnt,
    output logic             done,
    output logic             underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOAD, S_WAIT, S_SHIFT, S_CRC, S_HOLD
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_l;
    logic             cpol_l;
    logic [4:0]       last_bit_l;
    logic [NUM_W-1:0] tnum_l;
    logic             crc_en_l;
    logic [3:0]       setup_l;
    logic [3:0]       hold_l;
    logic             buf_full;
    logic [31:0]      buf_data;
    logic [3:0]       tcnt;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic             phase;

    logic             pop;
    logic             push;
    logic             tick;
    logic [NUM_W:0]   cnt_next;

    // A CRC frame_load never consumes the holding buffer.
    assign pop      = frame_load & ~crc_sel;
    assign wready   = ~buf_full | pop;
    assign push     = wvalid & wready;
    assign txe      = ~buf_full;
    assign busy     = (state != S_IDLE);
    assign tick     = (div_cnt == div_l);
    assign cnt_next = {1'b0, frame_cnt} + (NUM_W+1)'(1);

    function automatic logic tcnt_done(input logic [3:0] c, input logic [3:0] lim);
        return ({1'b0, c} + 5'd1) >= {1'b0, lim};
    endfunction

    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            state      <= S_IDLE;
            div_l      <= '0;
            cpol_l     <= 1'b0;
            last_bit_l <= 5'd7;
            tnum_l     <= NUM_W'(1);
            crc_en_l   <= 1'b0;
            setup_l    <= 4'd0;
            hold_l     <= 4'd0;
            buf_full   <= 1'b0;
            buf_data   <= 32'd0;
            tcnt       <= 4'd0;
            div_cnt    <= '0;
            bit_cnt    <= 5'd0;
            phase      <= 1'b0;
            cs_n       <= 1'b1;
            sck        <= cpol;
            frame_load <= 1'b0;
            frame_data <= 32'd0;
            crc_sel    <= 1'b0;
            bit_strobe <= 1'b0;
            frame_cnt  <= '0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_load <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;

            if (abort && state != S_IDLE) begin
                buf_full <= 1'b0;
            end else if (push) begin
                buf_full <= 1'b1;
                buf_data <= wdata;
            end else if (pop) begin
                buf_full <= 1'b0;
            end

            if (abort && state != S_IDLE) begin
                state   <= S_IDLE;
                cs_n    <= 1'b1;
                sck     <= cpol;
                crc_sel <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        sck  <= cpol;
                        cs_n <= 1'b1;
                        if (start && !abort) begin
                            div_l    <= clk_div;
                            cpol_l   <= cpol;
                            tnum_l   <= (tnum_max == '0) ? NUM_W'(1) : tnum_max;
                            crc_en_l <= crc_en;
                            setup_l  <= cs_setup;
                            hold_l   <= cs_hold;
                            case (df)
                                2'b00:   last_bit_l <= 5'd7;
                                2'b01:   last_bit_l <= 5'd15;
                                default: last_bit_l <= 5'd31;
                            endcase
                            frame_cnt <= '0;
                            underrun  <= 1'b0;
                            cs_n      <= 1'b0;
                            tcnt      <= 4'd0;
                            state     <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        if (tcnt_done(tcnt, setup_l)) state <= S_LOAD;
                        else tcnt <= tcnt + 4'd1;
                    end
                    S_LOAD: begin
                        if (buf_full) begin
                            frame_load <= 1'b1;
                            frame_data <= buf_data;
                            div_cnt    <= '0;
                            bit_cnt    <= 5'd0;
                            phase      <= 1'b0;
                            state      <= S_SHIFT;
                        end else begin
                            underrun <= 1'b1;
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (buf_full) state <= S_LOAD;
                    end
                    S_SHIFT, S_CRC: begin
                        // crc_sel doubles as the "CRC word already loaded" marker.
                        if (state == S_CRC && !crc_sel) begin
                            crc_sel    <= 1'b1;
                            frame_load <= 1'b1;
                            frame_data <= 32'd0;
                            div_cnt    <= '0;
                            bit_cnt    <= 5'd0;
                            phase      <= 1'b0;
                        end else if (tick) begin
                            div_cnt <= '0;
                            phase   <= ~phase;
                            if (!phase) begin
                                sck <= ~cpol_l;
                            end else begin
                                sck        <= cpol_l;
                                bit_strobe <= 1'b1;
                                bit_cnt    <= bit_cnt + 5'd1;
                                if (bit_cnt == last_bit_l) begin
                                    tcnt <= 4'd0;
                                    if (state == S_CRC) begin
                                        state <= S_HOLD;
                                    end else begin
                                        if (frame_cnt < tnum_l) frame_cnt <= cnt_next[NUM_W-1:0];
                                        if (cnt_next < {1'b0, tnum_l}) state <= S_LOAD;
                                        else if (crc_en_l)             state <= S_CRC;
                                        else                           state <= S_HOLD;
                                    end
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    S_HOLD: begin
                        // Keeps crc_sel high through the final CRC bit_strobe.
                        crc_sel <= 1'b0;
                        if (tcnt_done(tcnt, hold_l)) begin
                            cs_n  <= 1'b1;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
